// File: rtl/tiny_nn_pkg.sv
// Shared number format for the tiny_nn blocks: bfloat16-style fp_t (1/8/7),
// subnormals treated as zero, plus the special constants and classifiers.
package tiny_nn_pkg;

    typedef struct packed {
        logic       sgn;
        logic [7:0] exp;
        logic [6:0] man;
    } fp_t;

    localparam fp_t FPZero   = 16'h0000;
    localparam fp_t FPStdNaN = 16'h7FC0;
    localparam fp_t FPPosInf = 16'h7F80;
    localparam fp_t FPNegInf = 16'hFF80;

    function automatic logic is_nan(fp_t f);
        return (f.exp == 8'hFF) && (f.man != 7'd0);
    endfunction

    function automatic logic is_inf(fp_t f);
        return (f.exp == 8'hFF) && (f.man == 7'd0);
    endfunction

    // Exponent zero covers both true zero and flushed subnormals.
    function automatic logic is_zero(fp_t f);
        return (f.exp == 8'h00);
    endfunction

endpackage

// File: rtl/fp_add.sv
// Combinational fp_t adder: align, add/subtract, normalise, round to nearest even.
// Subnormal results flush to FPZero; overflow saturates to signed infinity.
module fp_add
    import tiny_nn_pkg::*;
(
    input  fp_t i_op_a,
    input  fp_t i_op_b,
    output fp_t o_sum
);

    fp_t         w_big;
    fp_t         w_small;
    logic        w_eff_sub;
    logic [7:0]  w_diff;
    logic [3:0]  w_shift;
    logic [10:0] w_m_big;
    logic [21:0] w_wide;
    logic [10:0] w_aligned;
    logic [11:0] w_raw;
    logic [3:0]  w_lz;
    logic [10:0] w_norm;
    logic [9:0]  w_exp;
    logic        w_round_up;
    logic [8:0]  w_mant;
    logic [9:0]  w_exp_r;
    fp_t         w_normal;

    always_comb begin
        if ({i_op_b.exp, i_op_b.man} > {i_op_a.exp, i_op_a.man}) begin
            w_big   = i_op_b;
            w_small = i_op_a;
        end else begin
            w_big   = i_op_a;
            w_small = i_op_b;
        end
        w_eff_sub = w_big.sgn ^ w_small.sgn;
        w_diff    = w_big.exp - w_small.exp;
        // Beyond 11 places every significant bit already lands in the sticky bit.
        w_shift   = (w_diff > 8'd11) ? 4'd11 : w_diff[3:0];
        w_m_big   = {1'b1, w_big.man, 3'b000};
        w_wide    = {1'b1, w_small.man, 3'b000, 11'd0} >> w_shift;
        w_aligned = {w_wide[21:12], w_wide[11] | (|w_wide[10:0])};
        w_raw     = w_eff_sub ? ({1'b0, w_m_big} - {1'b0, w_aligned})
                              : ({1'b0, w_m_big} + {1'b0, w_aligned});

        w_lz = 4'd0;
        for (int k = 0; k < 11; k++) begin
            if (w_raw[k]) w_lz = 4'(10 - k);
        end

        if (w_raw[11]) begin
            w_norm = {w_raw[11:2], w_raw[1] | w_raw[0]};
            w_exp  = {2'b00, w_big.exp} + 10'd1;
        end else begin
            w_norm = w_raw[10:0] << w_lz;
            w_exp  = {2'b00, w_big.exp} - {6'd0, w_lz};
        end

        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mant     = {1'b0, w_norm[10:3]} + {8'd0, w_round_up};
        w_exp_r    = w_exp + {9'd0, w_mant[8]};

        // A zero significand here means exact cancellation.
        if (!(w_mant[8] | w_mant[7]) || w_exp_r[9] || (w_exp_r == 10'd0))
            w_normal = FPZero;
        else if (w_exp_r >= 10'd255)
            w_normal = w_big.sgn ? FPNegInf : FPPosInf;
        else
            w_normal = '{sgn: w_big.sgn, exp: w_exp_r[7:0], man: w_mant[6:0]};
    end

    always_comb begin
        if (is_nan(i_op_a) || is_nan(i_op_b))
            o_sum = FPStdNaN;
        else if (is_inf(i_op_a) && is_inf(i_op_b))
            o_sum = (i_op_a.sgn == i_op_b.sgn) ? i_op_a : FPStdNaN;
        else if (is_inf(i_op_a))
            o_sum = i_op_a;
        else if (is_inf(i_op_b))
            o_sum = i_op_b;
        else if (is_zero(i_op_a) && is_zero(i_op_b))
            o_sum = FPZero;
        else if (is_zero(i_op_a))
            o_sum = i_op_b;
        else if (is_zero(i_op_b))
            o_sum = i_op_a;
        else
            o_sum = w_normal;
    end

endmodule

// File: rtl/fp_acc.sv
// Streaming fp_t accumulator: sums terms until in_last_i, then holds the sum for a
// valid/ready consumer. Optional output ReLU enabled by macro FP_ACC_RELU_EN.
module fp_acc
    import tiny_nn_pkg::*;
#(
    parameter int CntWidth = 8
)(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  fp_t                 in_data_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output fp_t                 out_data_o,
    output logic [CntWidth-1:0] out_count_o
);

    localparam logic [0:0]          ST_ACC = 1'b0;
    localparam logic [0:0]          ST_OUT = 1'b1;
    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [0:0]          r_state;
    fp_t                 r_acc;
    logic [CntWidth-1:0] r_cnt;
    fp_t                 w_sum;
    logic                w_in_hs;
    logic                w_out_hs;

    fp_add u_fp_add (
        .i_op_a (r_acc),
        .i_op_b (in_data_i),
        .o_sum  (w_sum)
    );

    assign in_ready_o  = (r_state == ST_ACC);
    assign out_valid_o = (r_state == ST_OUT);
    assign w_in_hs     = in_valid_i && in_ready_o;
    assign w_out_hs    = out_valid_o && out_ready_i;
    assign out_count_o = r_cnt;

`ifdef FP_ACC_RELU_EN
    // Clamp only what the consumer sees; the held sum itself stays signed.
    assign out_data_o = ((r_state == ST_OUT) && r_acc.sgn && !is_nan(r_acc)) ? FPZero : r_acc;
`else
    assign out_data_o = r_acc;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_ACC;
            r_acc   <= FPZero;
            r_cnt   <= '0;
        end else begin
            if (w_in_hs) begin
                r_acc <= w_sum;
                if (!(&r_cnt)) r_cnt <= r_cnt + CntOne;
                if (in_last_i) r_state <= ST_OUT;
            end
            if (w_out_hs) begin
                r_state <= ST_ACC;
                r_acc   <= FPZero;
                r_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_acc.sv
// Directed bench for fp_acc: a real-arithmetic model rounded to bfloat16 is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_fp_acc;
    import tiny_nn_pkg::*;

    localparam int CW     = 8;
    localparam int CntMax = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    fp_t           in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    fp_t           out_data;
    logic [CW-1:0] out_count;

    always #5 clk = ~clk;

    fp_acc #(.CntWidth(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_count_o (out_count)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    fp_t  m_acc       = FPZero;
    int   m_cnt       = 0;
    bit   m_hold      = 1'b0;
    bit   cmp_en      = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real to_real(fp_t f);
        logic [63:0] b;
        logic [10:0] e;
        if (f.exp == 8'h00) return 0.0;
        e = {3'b000, f.exp} + 11'd896;
        b = {f.sgn, e, f.man, 45'd0};
        return $bitstoreal(b);
    endfunction

    // Round a real to the nearest bfloat16 value, ties to even.
    function automatic fp_t from_real(real r);
        logic [63:0] b;
        int          e;
        logic [7:0]  m;
        logic [44:0] rem;
        if (r == 0.0) return FPZero;
        b   = $realtobits(r);
        e   = int'(b[62:52]) - 1023 + 127;
        m   = {1'b1, b[51:45]};
        rem = b[44:0];
        if (rem > 45'h1000_0000_0000 || (rem == 45'h1000_0000_0000 && m[0])) begin
            if (m == 8'hFF) begin
                m = 8'h80;
                e++;
            end else begin
                m++;
            end
        end
        if (e >= 255) return b[63] ? FPNegInf : FPPosInf;
        if (e <= 0) return FPZero;
        return fp_t'({b[63], e[7:0], m[6:0]});
    endfunction

    function automatic fp_t model_add(fp_t a, fp_t b);
        if (is_nan(a) || is_nan(b)) return FPStdNaN;
        if (is_inf(a) && is_inf(b)) return (a.sgn == b.sgn) ? a : FPStdNaN;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        return from_real(to_real(a) + to_real(b));
    endfunction

    function automatic fp_t relu(fp_t f);
`ifdef FP_ACC_RELU_EN
        return (f.sgn && !is_nan(f)) ? FPZero : f;
`else
        return f;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_acc  <= FPZero;
            m_cnt  <= 0;
            m_hold <= 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold <= 1'b0;
                m_acc  <= FPZero;
                m_cnt  <= 0;
            end
        end else if (in_valid) begin
            m_acc  <= model_add(m_acc, in_data);
            m_cnt  <= (m_cnt < CntMax) ? m_cnt + 1 : m_cnt;
            m_hold <= in_last;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_hold});
            check("out_data", {16'd0, out_data}, {16'd0, (m_hold ? relu(m_acc) : m_acc)});
            check("out_count", 32'(out_count), m_cnt);
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = fp_t'(16'($urandom));
    endtask

    task automatic send(fp_t d, bit last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(string name, fp_t exp_data, int exp_cnt);
        int lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 400) begin
            lat++;
            @(negedge clk);
        end
        check({name, "_latency"}, lat, 0);
        check({name, "_data"}, {16'd0, out_data}, {16'd0, exp_data});
        check({name, "_count"}, 32'(out_count), exp_cnt);
        $display("sum %s: data=%h count=%0d latency=%0d", name, out_data, out_count, lat);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_data", {16'd0, out_data}, 32'h0000);
        check("reset_count", 32'(out_count), 32'd0);
        @(posedge clk);
        #1;

        // simple sum with the consumer always ready
        out_ready = 1'b1;
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4040, 1'b1);
        idle();
        wait_out("simple", 16'h40C0, 3);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("simple_one_cycle", {31'd0, out_valid}, 32'd0);

        // backpressure: offered terms during OUT must be ignored
        send(16'h3FC0, 1'b0);
        send(16'hBF00, 1'b1);
        idle();
        wait_out("backpressure", 16'h3F80, 2);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h40E0;
            in_last  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_data", {16'd0, out_data}, 32'h3F80);
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        pop();
        idle();
        @(negedge clk);
        check("bp_resume_ready", {31'd0, in_ready}, 32'd1);
        check("bp_resume_count", 32'(out_count), 32'd0);

        // single term and exact cancellation
        send(16'h4080, 1'b1);
        idle();
        wait_out("single", 16'h4080, 1);
        pop();
        send(16'h4000, 1'b0);
        send(16'hC000, 1'b1);
        idle();
        wait_out("cancel", 16'h0000, 2);
        pop();

        // negative result: clamped only in the ReLU build
        send(16'h3F80, 1'b0);
        send(16'hC040, 1'b1);
        idle();
`ifdef FP_ACC_RELU_EN
        wait_out("relu", 16'h0000, 2);
`else
        wait_out("relu", 16'hC000, 2);
`endif
        pop();

        // specials
        send(FPPosInf, 1'b0);
        send(FPNegInf, 1'b1);
        idle();
        wait_out("inf_minus_inf", 16'h7FC0, 2);
        pop();
        send(16'h7FA5, 1'b0);
        send(16'h3F80, 1'b1);
        idle();
        wait_out("nan_sticky", 16'h7FC0, 2);
        pop();
        for (int i = 0; i < 300; i++) send(16'h3F80, (i == 299));
        idle();
        wait_out("count_sat", 16'h4380, 255);
        pop();

        // reset mid-sum discards the partial sum
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_valid", {31'd0, out_valid}, 32'd0);
        end
        send(16'h40A0, 1'b1);
        idle();
        wait_out("after_reset", 16'h40A0, 1);

        // reset while holding a result drops it
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_dropped", {31'd0, out_valid}, 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_acc.md
FP_ACC -- requirements
Module: fp_acc

Interface
REQ-001 SHALL have parameter CntWidth, default 8: width of the term counter.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid_i  input  1  input term valid.
REQ-005 SHALL have port in_ready_o  output  1  block can accept an input term.
REQ-006 SHALL have port in_data_i  input  fp_t  term to add.
REQ-007 SHALL have port in_last_i  input  1  marks the final term of the current sum.
REQ-008 SHALL have port out_valid_o  output  1  completed sum available.
REQ-009 SHALL have port out_ready_i  input  1  consumer accepts the sum.
REQ-010 SHALL have port out_data_o  output  fp_t  completed sum.
REQ-011 SHALL have port out_count_o  output  CntWidth  number of terms in the sum.

Function
REQ-012 SHALL implement a two-state FSM: ACC (accumulating) and OUT (holding result).
REQ-013 SHALL drive in_ready_o = 1 in ACC and 0 in OUT; out_valid_o = 1 in OUT and 0 in ACC.
REQ-014 SHALL define an input handshake as in_valid_i && in_ready_o, and an output handshake as out_valid_o && out_ready_i.
REQ-015 On an input handshake, SHALL register acc <= fp_add(acc, in_data_i) and cnt <= cnt + 1; cnt saturates at all-ones.
REQ-016 The adder SHALL be purely combinational, giving one term per cycle with no bubbles between accepted terms.
REQ-017 An input handshake with in_last_i = 1 SHALL update acc and cnt, then move to OUT on the next edge, so out_valid_o rises one cycle after the last handshake.
REQ-018 In OUT, out_data_o SHALL equal acc and out_count_o SHALL equal cnt; both SHALL stay stable until the output handshake.
REQ-019 On the output handshake, SHALL return to ACC with acc <= FPZero and cnt <= 0.
REQ-020 In ACC, out_data_o and out_count_o SHALL show the running acc and cnt, but they are not qualified by out_valid_o.
REQ-021 in_last_i and in_data_i SHALL be ignored whenever no input handshake occurs.
REQ-022 The first accepted term SHALL be added to FPZero, so a single-term sum equals that term.
REQ-023 NaN/Inf propagation SHALL follow fp_add: NaN is sticky, +Inf + -Inf gives FPStdNaN, and overflow gives signed Inf.
REQ-024 No input SHALL be accepted in the same cycle as an output handshake; the earliest new input handshake is the following cycle.

Reset
REQ-025 While rst_i = 1 at a clock edge: state <= ACC, acc <= FPZero, cnt <= 0.
REQ-026 After reset, outputs SHALL be: in_ready_o = 1, out_valid_o = 0, out_data_o = FPZero, out_count_o = 0.
REQ-027 Reset mid-sum or in OUT SHALL discard the partial sum or pending result without emitting it.

Configuration
REQ-028 Macro FP_ACC_RELU_EN SHALL control a ReLU on the output.
REQ-029 When FP_ACC_RELU_EN is defined, out_data_o in OUT SHALL be FPZero if acc.sgn = 1 and acc is not NaN; otherwise it is acc.
REQ-030 The ReLU SHALL apply to the output only; internal acc is unaffected.
REQ-031 When FP_ACC_RELU_EN is not defined, out_data_o SHALL be acc unmodified, including negative values.

Structure
REQ-032 fp_t, FPZero, FPStdNaN, FPPosInf, FPNegInf and is_nan/is_inf SHALL come from tiny_nn_pkg.
REQ-033 The FSM state enum SHALL be local to fp_acc and not placed in the package.
REQ-034 SHALL instantiate exactly one fp_add sub-module: op_a = acc, op_b = in_data_i, result feeds the acc register.

Verification
REQ-035 Scenario "simple sum": terms 1.0, 2.0, 3.0 (last on 3.0), out_ready_i = 1 -> out_valid_o high for one cycle, cycle after third handshake, out_data_o = 6.0, out_count_o = 3.
REQ-036 Scenario "backpressure": sum 1.5 + -0.5, out_ready_i low for 5 cycles -> out_valid_o held, out_data_o = 1.0 stable, in_ready_o = 0 throughout; ACC resumes after handshake.
REQ-037 Scenario "single term and cancellation": single term 4.0 with last -> 4.0, count 1; then 2.0 + -2.0 -> FPZero, count 2.
REQ-038 Scenario "ReLU build": with FP_ACC_RELU_EN, 1.0 + -3.0 -> out_data_o = FPZero; without the macro -> -2.0.
REQ-039 Scenario "specials": FPPosInf + FPNegInf -> FPStdNaN; NaN then 1.0 -> FPStdNaN; 300 terms with CntWidth = 8 -> out_count_o = 255.
REQ-040 Scenario "reset mid-sum": 2 terms accepted, then rst_i pulsed -> no out_valid_o; next sum 5.0 alone -> 5.0, count 1.
